// File: rtl/gtp_lane_align.sv
// GTP RX post-processor: per-lane K28.5 comma alignment, lock qualification,
// byte-swap correction and windowed decode-error supervision.

module gtp_lane_align_lane #(
  parameter int          LOCK_CNT  = 16,
  parameter int          ERR_LIMIT = 4,
  parameter int          ERR_WIN   = 1024,
  parameter int          CW        = 16,
  parameter logic [7:0]  COMMA     = 8'hBC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   i_rxdata,
  input  logic [1:0]    i_rxk,
  input  logic          i_rxerr,
  input  logic          i_err_clr,
  output logic [15:0]   o_data,
  output logic [1:0]    o_k,
  output logic          o_up,
  output logic [CW-1:0] o_err_cnt
);
  localparam int WW = $clog2(ERR_WIN);

  typedef enum logic [1:0] {LOS, ACQ, UP} st_t;

  st_t           r_st, w_st_nx;
  logic [7:0]    r_cnt, w_cnt_nx;
  logic          r_align, w_align_nx;
  logic [7:0]    r_werr, w_werr_nx;
  logic [WW-1:0] r_win;
  logic [15:0]   r_prev, r_data;
  logic [1:0]    r_prevk, r_k;
  logic          r_up;
  logic [CW-1:0] r_ecnt;

  logic          w_lo, w_hi, w_comma, w_calign, w_wrap;
  logic [8:0]    w_cnt_inc, w_werr_sum;

  // A word carrying commas in both bytes is treated as low-aligned.
  assign w_lo       = (i_rxdata[7:0] == COMMA) && i_rxk[0];
  assign w_hi       = (i_rxdata[15:8] == COMMA) && i_rxk[1];
  assign w_comma    = w_lo || w_hi;
  assign w_calign   = ~w_lo;
  assign w_wrap     = &r_win;
  assign w_cnt_inc  = {1'b0, r_cnt} + 9'd1;
  // The wrap cycle starts a fresh window; an error on it counts as the first.
  assign w_werr_sum = {1'b0, (w_wrap ? 8'd0 : r_werr)} + {8'd0, i_rxerr};

  always_comb begin
    w_st_nx    = r_st;
    w_cnt_nx   = r_cnt;
    w_align_nx = r_align;
    w_werr_nx  = '0;
    case (r_st)
      LOS: begin
        if (w_comma) begin
          w_st_nx    = ACQ;
          w_cnt_nx   = 8'd1;
          w_align_nx = w_calign;
        end
      end
      ACQ: begin
        if (i_rxerr) begin
          w_st_nx  = LOS;
          w_cnt_nx = 8'd0;
        end else if (w_comma) begin
          if (w_calign == r_align) begin
            w_cnt_nx = w_cnt_inc[7:0];
            if (w_cnt_inc == 9'(LOCK_CNT)) w_st_nx = UP;
          end else begin
            w_cnt_nx   = 8'd1;
            w_align_nx = w_calign;
          end
        end
      end
      UP: begin
        w_werr_nx = w_werr_sum[7:0];
        if (w_werr_sum >= 9'(ERR_LIMIT)) begin
          w_st_nx   = LOS;
          w_cnt_nx  = 8'd0;
          w_werr_nx = '0;
        end
      end
      default: w_st_nx = LOS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= LOS;
      r_cnt   <= '0;
      r_align <= 1'b0;
      r_werr  <= '0;
      r_win   <= '0;
      r_up    <= 1'b0;
    end else begin
      r_st    <= w_st_nx;
      r_cnt   <= w_cnt_nx;
      r_align <= w_align_nx;
      r_werr  <= w_werr_nx;
      r_win   <= r_win + 1'b1;
      r_up    <= (w_st_nx == UP);
    end
  end

  // Swapped lanes take the low byte of this word over the high byte of the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= '0;
      r_prevk <= '0;
      r_data  <= '0;
      r_k     <= '0;
    end else begin
      r_prev  <= i_rxdata;
      r_prevk <= i_rxk;
      r_data  <= r_align ? {i_rxdata[7:0], r_prev[15:8]} : i_rxdata;
      r_k     <= r_align ? {i_rxk[0], r_prevk[1]} : i_rxk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_ecnt <= '0;
    else if (i_err_clr)     r_ecnt <= CW'(i_rxerr);
    else if (i_rxerr && !(&r_ecnt)) r_ecnt <= r_ecnt + 1'b1;
  end

  assign o_data    = r_data;
  assign o_k       = r_k;
  assign o_up      = r_up;
  assign o_err_cnt = r_ecnt;
endmodule

module gtp_lane_align #(
  parameter int          NCH       = 4,
  parameter int          LOCK_CNT  = 16,
  parameter int          ERR_LIMIT = 4,
  parameter int          ERR_WIN   = 1024,
  parameter int          CW        = 16,
  parameter logic [7:0]  COMMA     = 8'hBC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*16-1:0] rxdata_i,
  input  logic [NCH*2-1:0]  rxcharisk_i,
  input  logic [NCH-1:0]    rxerr_i,
  input  logic              err_clr_i,
  output logic [NCH*16-1:0] data_o,
  output logic [NCH*2-1:0]  charisk_o,
  output logic [NCH-1:0]    valid_o,
  output logic [NCH-1:0]    link_up_o,
  output logic              all_up_o,
  output logic [NCH*CW-1:0] err_cnt_o
);
  logic [NCH-1:0] w_up;
  logic           r_all_up;

  for (genvar n = 0; n < NCH; n++) begin : g_lane
    gtp_lane_align_lane #(
      .LOCK_CNT (LOCK_CNT),
      .ERR_LIMIT(ERR_LIMIT),
      .ERR_WIN  (ERR_WIN),
      .CW       (CW),
      .COMMA    (COMMA)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_rxdata (rxdata_i[16*n +: 16]),
      .i_rxk    (rxcharisk_i[2*n +: 2]),
      .i_rxerr  (rxerr_i[n]),
      .i_err_clr(err_clr_i),
      .o_data   (data_o[16*n +: 16]),
      .o_k      (charisk_o[2*n +: 2]),
      .o_up     (w_up[n]),
      .o_err_cnt(err_cnt_o[CW*n +: CW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_all_up <= 1'b0;
    else        r_all_up <= &w_up;
  end

  assign valid_o   = w_up;
  assign link_up_o = w_up;
  assign all_up_o  = r_all_up;
endmodule

// File: tb/tb_gtp_lane_align.sv
// Directed bench for gtp_lane_align: lock, swap alignment, relock on
// alignment change, windowed error drop, counter saturation/clear, reset.

module tb_gtp_lane_align;
  localparam int NCH = 4;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*16-1:0] rxdata_i;
  logic [NCH*2-1:0]  rxcharisk_i;
  logic [NCH-1:0]    rxerr_i;
  logic              err_clr_i;
  logic [NCH*16-1:0] data_o;
  logic [NCH*2-1:0]  charisk_o;
  logic [NCH-1:0]    valid_o, link_up_o;
  logic              all_up_o;
  logic [NCH*CW-1:0] err_cnt_o;

  logic [15:0] d [NCH];
  logic [1:0]  k [NCH];
  logic        e [NCH];

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  gtp_lane_align #(.NCH(NCH), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxdata_i   (rxdata_i),
    .rxcharisk_i(rxcharisk_i),
    .rxerr_i    (rxerr_i),
    .err_clr_i  (err_clr_i),
    .data_o     (data_o),
    .charisk_o  (charisk_o),
    .valid_o    (valid_o),
    .link_up_o  (link_up_o),
    .all_up_o   (all_up_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    rxdata_i    = '0;
    rxcharisk_i = '0;
    rxerr_i     = '0;
    for (int n = 0; n < NCH; n++) begin
      rxdata_i[16*n +: 16]  = d[n];
      rxcharisk_i[2*n +: 2] = k[n];
      rxerr_i[n]            = e[n];
    end
  end

  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    err_clr_i = 1'b0;
    for (int n = 0; n < NCH; n++) begin d[n] = '0; k[n] = '0; e[n] = 1'b0; end
    #23;
    chk("rst_data",  64'(data_o),    64'h0);
    chk("rst_k",     64'(charisk_o), 64'h0);
    chk("rst_up",    64'(link_up_o), 64'h0);
    chk("rst_valid", 64'(valid_o),   64'h0);
    chk("rst_allup", 64'(all_up_o),  64'h0);
    chk("rst_err",   64'(err_cnt_o), 64'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // lane 0: 16 low-aligned commas
    d[0] = 16'h50BC; k[0] = 2'b01;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("l0_not_up_15", 64'(link_up_o[0]), 64'h0);
    end
    chk("l0_up",    64'(link_up_o[0]),  64'h1);
    chk("l0_valid", 64'(valid_o[0]),    64'h1);
    chk("l0_data",  64'(data_o[15:0]),  64'h50BC);
    chk("l0_k",     64'(charisk_o[1:0]), 64'h1);
    chk("l0_allup", 64'(all_up_o),      64'h0);

    // lane 1: byte-swapped commas then data
    d[1] = 16'hBC50; k[1] = 2'b10;
    for (int i = 1; i <= 16; i++) tick();
    chk("l1_up",     64'(link_up_o[1]),   64'h1);
    chk("l1_comma",  64'(data_o[31:16]),  64'h50BC);
    chk("l1_commak", 64'(charisk_o[3:2]), 64'h1);
    d[1] = 16'h2211; k[1] = 2'b00;
    tick();
    chk("l1_w0",  64'(data_o[31:16]),  64'h11BC);
    chk("l1_k0",  64'(charisk_o[3:2]), 64'h1);
    d[1] = 16'h4433;
    tick();
    chk("l1_w1",  64'(data_o[31:16]),  64'h3322);
    chk("l1_k1",  64'(charisk_o[3:2]), 64'h0);
    chk("l1_still_up", 64'(link_up_o[1]), 64'h1);

    // lane 2: alignment flip restarts the lock count
    d[2] = 16'h50BC; k[2] = 2'b01;
    for (int i = 0; i < 10; i++) tick();
    d[2] = 16'hBC50; k[2] = 2'b10;
    tick();
    d[2] = 16'h50BC; k[2] = 2'b01;
    for (int i = 0; i < 15; i++) tick();
    chk("l2_not_up_15", 64'(link_up_o[2]), 64'h0);
    tick();
    chk("l2_up_16", 64'(link_up_o[2]), 64'h1);

    // lane 3 lock, then all_up one cycle later
    d[3] = 16'h50BC; k[3] = 2'b01;
    for (int i = 0; i < 16; i++) tick();
    chk("l3_up",        64'(link_up_o), 64'hF);
    chk("allup_lag",    64'(all_up_o),  64'h0);
    tick();
    chk("allup_rise",   64'(all_up_o),  64'h1);

    // three errors in one window keep the link
    for (int i = 0; i < 3; i++) begin e[3] = 1'b1; tick(); e[3] = 1'b0; tick(); end
    chk("l3_3err_up",  64'(link_up_o[3]),  64'h1);
    chk("l3_3err_cnt", 64'(err_cnt_o[15:12]), 64'h3);
    // window wrap clears the window count
    while (cyc < 1100) tick();
    e[3] = 1'b1; tick(); e[3] = 1'b0; tick();
    chk("l3_wrap_up",  64'(link_up_o[3]),  64'h1);
    chk("l3_wrap_cnt", 64'(err_cnt_o[15:12]), 64'h4);
    for (int i = 0; i < 2; i++) begin e[3] = 1'b1; tick(); e[3] = 1'b0; tick(); end
    chk("l3_3win_up",  64'(link_up_o[3]),  64'h1);
    e[3] = 1'b1; tick(); e[3] = 1'b0;
    d[3] = '0; k[3] = '0;
    chk("l3_drop",       64'(link_up_o[3]), 64'h0);
    chk("allup_hold",    64'(all_up_o),     64'h1);
    tick();
    chk("allup_fall",    64'(all_up_o),     64'h0);
    chk("l3_drop_cnt",   64'(err_cnt_o[15:12]), 64'h7);

    // saturation at 2^CW-1 and clear behaviour
    d[2] = '0; k[2] = '0; e[2] = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("l2_sat",     64'(err_cnt_o[11:8]), 64'hF);
    chk("l2_dropped", 64'(link_up_o[2]),    64'h0);
    err_clr_i = 1'b1;
    tick();
    chk("clr_with_err", 64'(err_cnt_o[11:8]), 64'h1);
    e[2] = 1'b0;
    tick();
    err_clr_i = 1'b0;
    chk("clr_alone", 64'(err_cnt_o), 64'h0);

    // relock lanes 2,3 then reset mid-operation
    d[2] = 16'h50BC; k[2] = 2'b01; d[3] = 16'h50BC; k[3] = 2'b01;
    for (int i = 0; i < 16; i++) tick();
    chk("relock_all", 64'(link_up_o), 64'hF);
    tick();
    chk("relock_allup", 64'(all_up_o), 64'h1);
    e[0] = 1'b1; tick(); e[0] = 1'b0;
    chk("l0_err1", 64'(err_cnt_o[3:0]), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_up",    64'(link_up_o), 64'h0);
    chk("arst_valid", 64'(valid_o),   64'h0);
    chk("arst_allup", 64'(all_up_o),  64'h0);
    chk("arst_err",   64'(err_cnt_o), 64'h0);
    chk("arst_data",  64'(data_o),    64'h0);
    chk("arst_k",     64'(charisk_o), 64'h0);
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("rst_relock_15", 64'(link_up_o[0]), 64'h0);
    end
    chk("rst_relock_16", 64'(link_up_o[0]), 64'h1);
    chk("rst_l1_down",   64'(link_up_o[1]), 64'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
